// File: rtl/bimodal_btb_predictor.sv
// rtl/bimodal_btb_predictor.sv - direct-mapped BTB with saturating direction counters and stats
module bimodal_btb_predictor #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 8,
  parameter int CTR_BITS   = 2,
  parameter int STAT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] read_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 upd_valid,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_is_jump,
  input  logic                 upd_pred_taken,
  input  logic [WORD_SIZE-1:0] upd_pred_target,
  input  logic                 invalidate_all,
  output logic [STAT_BITS-1:0] stat_updates,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = WORD_SIZE - INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q [DEPTH];
  logic [WORD_SIZE-1:0] tgt_q [DEPTH];
  logic [CTR_BITS-1:0]  ctr_q [DEPTH];

  logic [STAT_BITS-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_BITS-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [INDEX_BITS-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0]      rd_tag, upd_tag;
  logic                  upd_hit, wr_en, mispredict;
  logic [CTR_BITS-1:0]   cur_ctr, ctr_d;
  logic [WORD_SIZE-1:0]  tgt_d;

  assign rd_idx  = read_pc[INDEX_BITS-1:0];
  assign rd_tag  = read_pc[WORD_SIZE-1:INDEX_BITS];
  assign upd_idx = upd_pc[INDEX_BITS-1:0];
  assign upd_tag = upd_pc[WORD_SIZE-1:INDEX_BITS];

  // Lookup sees only registered state, so a same-cycle update is never forwarded.
  assign pred_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken  = pred_hit && ctr_q[rd_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? tgt_q[rd_idx] : read_pc + WORD_SIZE'(1);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign cur_ctr = ctr_q[upd_idx];

  always_comb begin
    wr_en = 1'b0;
    ctr_d = cur_ctr;
    tgt_d = tgt_q[upd_idx];
    if (upd_valid && !invalidate_all) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          ctr_d = CTR_MAX;
          tgt_d = upd_target;
        end else if (upd_taken) begin
          ctr_d = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_BITS'(1);
          tgt_d = upd_target;
        end else begin
          ctr_d = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        wr_en = 1'b1;
        ctr_d = upd_is_jump ? CTR_MAX : CTR_WEAK;
        tgt_d = upd_target;
      end
    end
  end

  assign mispredict = (upd_pred_taken != upd_taken) ||
                      (upd_taken && (upd_pred_target != upd_target));

  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid) begin
      if (stat_updates_q != '1)
        stat_updates_d = stat_updates_q + STAT_BITS'(1);
      if (mispredict && (stat_mispredicts_q != '1))
        stat_mispredicts_d = stat_mispredicts_q + STAT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q            <= '0;
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
      if (invalidate_all)
        valid_q <= '0;
      else if (wr_en)
        valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload fields are meaningless while the valid bit is clear, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= tgt_d;
      ctr_q[upd_idx] <= ctr_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
